fp32_adder_multiplier: RTL and testbench
========================================

Name: fp32_adder_multiplier

Overview:
- Single-precision (IEEE-754 binary32) arithmetic block.
- Computes a+b and a*b in parallel from one operand pair and returns both results with per-result overflow flags.
- Used as a registered arithmetic leaf in the datapath.
- Combinational add/multiply cores feed one output register stage.

Parameters:
- None. The format is fixed at binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a/b valid this cycle
- a  in  32  operand A, binary32
- b  in  32  operand B, binary32
- out_valid  out  1  results valid; in_valid delayed by one cycle
- add_result  out  32  binary32 a+b
- add_overflow  out  1  a+b overflowed from finite operands
- mul_result  out  32  binary32 a*b
- mul_overflow  out  1  a*b overflowed from finite operands

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid, add_result, add_overflow, mul_result and mul_overflow all clear to 0 immediately.
  - They stay 0 while reset is held.
  - The first capture happens on the first rising edge after rst_n deasserts.
- Latency: exactly 1 cycle.
  - On each rising edge, all four result outputs register the function of the current a/b.
  - out_valid registers in_valid.
  - Results update every cycle regardless of in_valid; in_valid only qualifies out_valid.
  - No stall and no backpressure: one operation per cycle.
- Subnormals: flush-to-zero on inputs (exponent 0 is treated as ±0) and on outputs (a result below 2^-126 becomes ±0 with its sign kept; no flag).
- Rounding: round-to-nearest-even.
  - Use guard, round and sticky bits.
  - A rounding carry renormalises the result and increments the exponent.
- Adder:
  - Align the smaller-magnitude operand by the exponent difference, collecting shifted-out bits into sticky.
  - A shift of 26 or more leaves only sticky.
  - Add magnitudes when signs match; otherwise subtract the smaller from the larger, and the result takes the sign of the larger.
  - Normalise with a leading-zero count, then round.
  - An exact zero from opposite signs gives +0; (-0)+(-0) gives -0.
- Multiplier:
  - Sign = sa XOR sb.
  - Exponent = ea+eb-127.
  - Form the 24x24 significand product (48 bits) and normalise by at most 1 bit.
  - Round, then check the exponent range.
- Overflow: if the final biased exponent is 255 or more with finite operands, the result is ±infinity (exp=0xFF, frac=0) with the computed sign and the matching overflow flag is 1. Otherwise the flag is 0.
- Specials (both flags are 0 in all of these):
  - Any NaN input: canonical quiet NaN 0x7FC00000.
  - Add: inf+(-inf) gives 0x7FC00000; inf+finite gives that inf.
  - Mul: 0*inf gives 0x7FC00000; inf*nonzero gives inf with the XOR sign.
  - Mul: zero*finite gives signed zero.
- Reset mid-operation: pending results are discarded and the outputs show 0.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately, with no clock edge. Release, drive a=0x3F800000, b=0xBF800000, in_valid=1 -> next cycle out_valid=1, add_result=0x00000000, mul_result=0xBF800000, flags 0.
- Mixed sign: a=0xC0B00000 (-5.5), b=0x40100000 (2.25) -> add_result=0xC0500000 (-3.25), mul_result=0xC1460000 (-12.375), flags 0.
- Rounding: a=0x40E66666 (7.2), b=0x404CCCCD (3.2) -> add_result=0x41266666 (10.4). mul_result must match a reference RNE model bit-exactly (≈23.04). Also a=0x3DCCCCCD (0.1), b=0x3E4CCCCD (0.2) -> add_result=0x3E99999A.
- Overflow: a=b=0x7F7FFFFF -> add_result=0x7F800000, add_overflow=1, mul_result=0x7F800000, mul_overflow=1. Then a=0xFF000000, b=0x40000000 -> mul_result=0xFF800000, mul_overflow=1.
- Specials: a=0x7F800000, b=0xFF800000 -> add_result=0x7FC00000, mul_result=0xFF800000, flags 0. Also a=0x00000000, b=0x7F800000 -> mul_result=0x7FC00000. Also a=0x7FC00001 with any b -> both results 0x7FC00000.
- Throughput/flush: back-to-back random operand pairs with in_valid toggling -> each result appears exactly 1 cycle later and matches the model. Also a=0x00400000 (subnormal), b=0x3F800000 -> add_result=0x3F800000.

Source files
------------

// File: rtl/fp32_adder_multiplier_if.sv
// Operand/result bundle for the registered binary32 add/multiply leaf.
interface fp32_adder_multiplier_if;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] add_result;
  logic        add_overflow;
  logic [31:0] mul_result;
  logic        mul_overflow;

  modport master (
    output in_valid, a, b,
    input  out_valid, add_result, add_overflow, mul_result, mul_overflow
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, add_result, add_overflow, mul_result, mul_overflow
  );
endinterface

// File: rtl/fp32_adder_multiplier.sv
// Binary32 a+b and a*b computed combinationally from one operand pair, then registered once.
// Flush-to-zero on inputs and outputs, round-to-nearest-even, canonical quiet NaN.
module fp32_adder_multiplier (
  input logic                    clk,
  input logic                    rst_n,
  fp32_adder_multiplier_if.slave bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // n holds 24 significand bits followed by guard, round and sticky; returns {overflow, result}.
  function automatic logic [32:0] round_pack(input logic sign, input logic signed [9:0] exp_in,
                                             input logic [26:0] n);
    logic              round_up;
    logic [24:0]       rounded;
    logic [22:0]       frac;
    logic signed [9:0] exp_out;
    round_up = n[2] & (n[1] | n[0] | n[3]);
    rounded  = {1'b0, n[26:3]} + {24'd0, round_up};
    if (rounded[24]) begin
      frac    = rounded[23:1];
      exp_out = exp_in + 10'sd1;
    end else begin
      frac    = rounded[22:0];
      exp_out = exp_in;
    end
    if (exp_out >= 10'sd255)
      round_pack = {1'b1, sign, 8'hFF, 23'd0};
    else if (exp_out <= 10'sd0)
      round_pack = {1'b0, sign, 31'd0};
    else
      round_pack = {1'b0, sign, exp_out[7:0], frac};
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, any_nan;
  logic [23:0] ma, mb;

  assign {sa, ea, fa} = bus.a;
  assign {sb, eb, fb} = bus.b;
  assign a_zero  = (ea == 8'd0);
  assign b_zero  = (eb == 8'd0);
  assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
  assign any_nan = ((ea == 8'hFF) && (fa != 23'd0)) || ((eb == 8'hFF) && (fb != 23'd0));
  assign ma      = a_zero ? 24'd0 : {1'b1, fa};
  assign mb      = b_zero ? 24'd0 : {1'b1, fb};

  logic              a_bigger, big_sign;
  logic [7:0]        big_exp, small_exp, shift;
  logic [23:0]       big_man, small_man;
  logic [49:0]       wide;
  logic [26:0]       aligned, add_norm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] add_exp;
  logic [32:0]       add_next;

  // Adder: align the smaller magnitude, add/subtract, normalise, round, then override specials.
  always_comb begin
    a_bigger  = {ea, ma} >= {eb, mb};
    big_sign  = a_bigger ? sa : sb;
    big_exp   = a_bigger ? ea : eb;
    small_exp = a_bigger ? eb : ea;
    big_man   = a_bigger ? ma : mb;
    small_man = a_bigger ? mb : ma;
    shift     = big_exp - small_exp;
    wide      = {small_man, 26'd0} >> shift;
    if (shift >= 8'd26)
      aligned = {26'd0, |small_man};
    else
      aligned = {wide[49:24], |wide[23:0]};
    if (sa == sb)
      sum = {1'b0, big_man, 3'd0} + {1'b0, aligned};
    else
      sum = {1'b0, big_man, 3'd0} - {1'b0, aligned};
    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      add_norm = {sum[27:2], sum[1] | sum[0]};
      add_exp  = $signed({2'b00, big_exp}) + 10'sd1;
    end else begin
      add_norm = sum[26:0] << lz;
      add_exp  = $signed({2'b00, big_exp}) - $signed({5'd0, lz});
    end
    add_next = round_pack(big_sign, add_exp, add_norm);
    if (any_nan)
      add_next = {1'b0, QNAN};
    else if (a_inf && b_inf)
      add_next = (sa != sb) ? {1'b0, QNAN} : {1'b0, bus.a};
    else if (a_inf)
      add_next = {1'b0, bus.a};
    else if (b_inf)
      add_next = {1'b0, bus.b};
    else if (sum == 28'd0)
      add_next = {1'b0, sa & sb, 31'd0};
  end

  logic              mul_sign;
  logic [47:0]       prod;
  logic [26:0]       mul_norm;
  logic signed [9:0] mul_exp;
  logic [32:0]       mul_next;

  // Multiplier: the 48-bit product of normalised significands needs at most a 1-bit shift.
  always_comb begin
    mul_sign = sa ^ sb;
    prod     = {24'd0, ma} * {24'd0, mb};
    mul_exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      mul_norm = {prod[47:22], |prod[21:0]};
      mul_exp  = mul_exp + 10'sd1;
    end else begin
      mul_norm = {prod[46:21], |prod[20:0]};
    end
    mul_next = round_pack(mul_sign, mul_exp, mul_norm);
    if (any_nan || (a_inf && b_zero) || (a_zero && b_inf))
      mul_next = {1'b0, QNAN};
    else if (a_inf || b_inf)
      mul_next = {1'b0, mul_sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero)
      mul_next = {1'b0, mul_sign, 31'd0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid    <= 1'b0;
      bus.add_result   <= 32'd0;
      bus.add_overflow <= 1'b0;
      bus.mul_result   <= 32'd0;
      bus.mul_overflow <= 1'b0;
    end else begin
      bus.out_valid    <= bus.in_valid;
      bus.add_result   <= add_next[31:0];
      bus.add_overflow <= add_next[32];
      bus.mul_result   <= mul_next[31:0];
      bus.mul_overflow <= mul_next[32];
    end
  end

endmodule

// File: tb/tb_fp32_adder_multiplier.sv
// Bench for fp32_adder_multiplier: directed corner cases plus random back-to-back traffic,
// checked against an exact-integer binary32 reference model.
module tb_fp32_adder_multiplier;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic        prev_valid;
  logic [32:0] prev_add, prev_mul;

  fp32_adder_multiplier_if bus();

  fp32_adder_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'd0;
  endfunction

  // Exact value sign * mag * 2^e rounded to 24 significant bits (RNE), then range-checked.
  function automatic logic [32:0] model_round(input logic sign, input logic [299:0] mag, input int e);
    logic [299:0] q, rem, half;
    int p, sh, biased;
    if (mag == '0) return {1'b0, sign, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++)
      if (mag[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 300'(1);
    end else begin
      q = mag << (23 - p);
    end
    biased = p + e + 127;
    if (q[24]) begin
      q = q >> 1;
      biased++;
    end
    if (biased >= 255) return {1'b1, sign, 8'hFF, 23'd0};
    if (biased <= 0) return {1'b0, sign, 31'd0};
    return {1'b0, sign, biased[7:0], q[22:0]};
  endfunction

  function automatic logic [32:0] model_add(input logic [31:0] x, input logic [31:0] y);
    logic [299:0] tx, ty, mag;
    logic sign;
    int ex, ey, emin;
    if (is_nan(x) || is_nan(y)) return {1'b0, QNAN};
    if (is_inf(x) && is_inf(y)) return (x[31] != y[31]) ? {1'b0, QNAN} : {1'b0, x};
    if (is_inf(x)) return {1'b0, x};
    if (is_inf(y)) return {1'b0, y};
    if (is_zero(x) && is_zero(y)) return {1'b0, x[31] & y[31], 31'd0};
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if (is_zero(x)) emin = ey;
    else if (is_zero(y)) emin = ex;
    else emin = (ex < ey) ? ex : ey;
    tx = is_zero(x) ? '0 : (300'({1'b1, x[22:0]}) << (ex - emin));
    ty = is_zero(y) ? '0 : (300'({1'b1, y[22:0]}) << (ey - emin));
    if (x[31] == y[31]) begin
      mag = tx + ty; sign = x[31];
    end else if (tx >= ty) begin
      mag = tx - ty; sign = x[31];
    end else begin
      mag = ty - tx; sign = y[31];
    end
    if (mag == '0) return {1'b0, x[31] & y[31], 31'd0};
    return model_round(sign, mag, emin - 150);
  endfunction

  function automatic logic [32:0] model_mul(input logic [31:0] x, input logic [31:0] y);
    logic sign;
    logic [299:0] mag;
    sign = x[31] ^ y[31];
    if (is_nan(x) || is_nan(y)) return {1'b0, QNAN};
    if ((is_inf(x) && is_zero(y)) || (is_zero(x) && is_inf(y))) return {1'b0, QNAN};
    if (is_inf(x) || is_inf(y)) return {1'b0, sign, 8'hFF, 23'd0};
    if (is_zero(x) || is_zero(y)) return {1'b0, sign, 31'd0};
    mag = 300'({1'b1, x[22:0]}) * 300'({1'b1, y[22:0]});
    return model_round(sign, mag, int'(x[30:23]) + int'(y[30:23]) - 300);
  endfunction

  task automatic check_output(input string tag, input logic exp_valid, input logic [31:0] exp_add,
                              input logic exp_add_ovf, input logic [31:0] exp_mul, input logic exp_mul_ovf);
    vectors++;
    assert (bus.out_valid === exp_valid) else begin
      miscompares++;
      $error("[TB] FAIL %s out_valid got %b want %b", tag, bus.out_valid, exp_valid);
    end
    vectors++;
    assert (bus.add_result === exp_add) else begin
      miscompares++;
      $error("[TB] FAIL %s add_result got %h want %h (a=%h b=%h)", tag, bus.add_result, exp_add, bus.a, bus.b);
    end
    vectors++;
    assert (bus.add_overflow === exp_add_ovf) else begin
      miscompares++;
      $error("[TB] FAIL %s add_overflow got %b want %b", tag, bus.add_overflow, exp_add_ovf);
    end
    vectors++;
    assert (bus.mul_result === exp_mul) else begin
      miscompares++;
      $error("[TB] FAIL %s mul_result got %h want %h (a=%h b=%h)", tag, bus.mul_result, exp_mul, bus.a, bus.b);
    end
    vectors++;
    assert (bus.mul_overflow === exp_mul_ovf) else begin
      miscompares++;
      $error("[TB] FAIL %s mul_overflow got %b want %b", tag, bus.mul_overflow, exp_mul_ovf);
    end
  endtask

  // Drive at the falling edge; outputs must still hold the previous result until the next rising edge.
  task automatic apply_stimulus(input string tag, input logic v, input logic [31:0] x, input logic [31:0] y,
                                input logic [32:0] exp_add, input logic [32:0] exp_mul);
    @(negedge clk);
    bus.in_valid = v;
    bus.a = x;
    bus.b = y;
    #1;
    check_output({tag, "_hold"}, prev_valid, prev_add[31:0], prev_add[32], prev_mul[31:0], prev_mul[32]);
    @(posedge clk);
    #1;
    check_output(tag, v, exp_add[31:0], exp_add[32], exp_mul[31:0], exp_mul[32]);
    prev_valid = v;
    prev_add = exp_add;
    prev_mul = exp_mul;
  endtask

  task automatic apply_model(input string tag, input logic v, input logic [31:0] x, input logic [31:0] y);
    apply_stimulus(tag, v, x, y, model_add(x, y), model_mul(x, y));
  endtask

  task automatic random_pair(output logic [31:0] x, output logic [31:0] y);
    int sel;
    x = $urandom();
    y = $urandom();
    sel = $urandom_range(0, 3);
    if (sel == 1) begin
      y[30:23] = x[30:23] ^ 8'($urandom_range(0, 3));
    end else if (sel == 2) begin
      x[30:23] = 8'($urandom_range(100, 154));
      y[30:23] = 8'($urandom_range(100, 154));
    end else if (sel == 3) begin
      y = {~x[31], x[30:0]} ^ 32'($urandom_range(0, 7));
    end
  endtask

  initial begin
    logic [31:0] x, y;
    prev_valid = 1'b0;
    prev_add = '0;
    prev_mul = '0;
    bus.in_valid = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    rst_n = 1'b1;

    #2 rst_n = 1'b0;
    #1 check_output("reset_async", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    bus.in_valid = 1'b1;
    bus.a = 32'h3F80_0000;
    bus.b = 32'h4000_0000;
    @(posedge clk);
    #1 check_output("reset_hold", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      random_pair(x, y);
      apply_model("warmup", 1'b1, x, y);
    end

    // Reset mid-stream, asynchronously, between clock edges.
    #2 rst_n = 1'b0;
    #1 check_output("midreset_async", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 check_output("midreset_hold", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    prev_valid = 1'b0;
    prev_add = '0;
    prev_mul = '0;
    #1 rst_n = 1'b1;

    apply_stimulus("one_minus_one", 1'b1, 32'h3F80_0000, 32'hBF80_0000, {1'b0, 32'h0000_0000}, {1'b0, 32'hBF80_0000});
    apply_stimulus("mixed_sign", 1'b1, 32'hC0B0_0000, 32'h4010_0000, {1'b0, 32'hC050_0000}, {1'b0, 32'hC146_0000});
    apply_stimulus("round_7p2_3p2", 1'b1, 32'h40E6_6666, 32'h404C_CCCD, {1'b0, 32'h4126_6666},
                   model_mul(32'h40E6_6666, 32'h404C_CCCD));
    apply_stimulus("round_0p1_0p2", 1'b0, 32'h3DCC_CCCD, 32'h3E4C_CCCD, {1'b0, 32'h3E99_999A},
                   model_mul(32'h3DCC_CCCD, 32'h3E4C_CCCD));
    apply_stimulus("ovf_max_max", 1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, {1'b1, 32'h7F80_0000}, {1'b1, 32'h7F80_0000});
    apply_stimulus("ovf_mul_neg", 1'b1, 32'hFF00_0000, 32'h4000_0000, model_add(32'hFF00_0000, 32'h4000_0000),
                   {1'b1, 32'hFF80_0000});
    apply_stimulus("inf_minus_inf", 1'b1, 32'h7F80_0000, 32'hFF80_0000, {1'b0, QNAN}, {1'b0, 32'hFF80_0000});
    apply_stimulus("zero_times_inf", 1'b1, 32'h0000_0000, 32'h7F80_0000, {1'b0, 32'h7F80_0000}, {1'b0, QNAN});
    apply_stimulus("nan_in", 1'b1, 32'h7FC0_0001, $urandom(), {1'b0, QNAN}, {1'b0, QNAN});
    apply_stimulus("subnormal_flush", 1'b1, 32'h0040_0000, 32'h3F80_0000, {1'b0, 32'h3F80_0000}, {1'b0, 32'h0000_0000});
    apply_stimulus("neg_zero_sum", 1'b1, 32'h8000_0000, 32'h8000_0000, {1'b0, 32'h8000_0000}, {1'b0, 32'h0000_0000});

    for (int i = 0; i < 250; i++) begin
      random_pair(x, y);
      apply_model("random", 1'($urandom_range(0, 1)), x, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
